uart_tx_buffered: RTL and testbench



---
 rtl/uart_tx_buffered_if.sv | 25 ++
 rtl/uart_tx_buffered.sv | 151 +++++++++++++++
 tb/tb_uart_tx_buffered.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_buffered_if.sv
// Byte-producer side of the buffered UART transmitter: write strobe, FIFO status and line outputs.
// master = producer/testbench, slave = the transmitter.
interface uart_tx_buffered_if #(
    parameter int FIFO_DEPTH = 8
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]    din;
    logic          wr_en;
    logic          full;
    logic [CW-1:0] fifo_count;
    logic          overflow;
    logic          tx;
    logic          tx_busy;

    modport master (
        output din, wr_en,
        input  full, fifo_count, overflow, tx, tx_busy
    );

    modport slave (
        input  din, wr_en,
        output full, fifo_count, overflow, tx, tx_busy
    );
endinterface

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: byte FIFO feeding an 8N1/8N2 serialiser.
// tx and tx_busy are registered from the current FSM state, so both trail the state by one clock.
module uart_tx_buffered #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk_50m,
    input  logic              rst_n,
    uart_tx_buffered_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          full, empty, push, pop;
    logic          overflow_q;

    state_e        state_q, state_d;
    logic [15:0]   baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          baud_done;

    // full/empty come from the registered count, so a same-edge pop never frees a slot for a write
    assign full      = (count_q == CW'(FIFO_DEPTH));
    assign empty     = (count_q == '0);
    assign push      = bus.wr_en && !full;
    assign baud_done = (baud_q == BAUD_LAST);

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_50m) begin
        if (push) mem_q[wr_ptr_q] <= bus.din;
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q    <= count_d;
            overflow_q <= bus.wr_en && full;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
                        state_d = STOP;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            STOP: begin
                // bit_q counts stop bits here
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_q == STOP_LAST) state_d = IDLE;
                    else                    bit_d   = bit_q + 3'd1;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_d = 1'b1;
        unique case (state_q)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_q[0];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_q != IDLE) || !empty;
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.full       = full;
    assign bus.fifo_count = count_q;
    assign bus.overflow   = overflow_q;
    assign bus.tx         = tx_q;
    assign bus.tx_busy    = busy_q;
endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: a 115200-baud instance (A) and a fast 8N2 instance (B) with a
// bit-sampling receiver per instance popping a byte scoreboard.
module tb_uart_tx_buffered;
    localparam int CPB_A  = 434;
    localparam int STOP_A = 1;
    localparam int CPB_B  = 4;
    localparam int STOP_B = 2;
    localparam int DEPTH  = 8;

    typedef struct {
        logic       wr;
        logic [7:0] din;
        int         cnt;
        logic       full;
        logic       ovf;
    } vec_t;

    typedef struct {
        logic lvl;
        int   len;
    } run_t;

    logic clk_50m = 1'b0;
    logic rst_n   = 1'b0;
    always #10 clk_50m = ~clk_50m;

    uart_tx_buffered_if #(.FIFO_DEPTH(DEPTH)) ifa ();
    uart_tx_buffered_if #(.FIFO_DEPTH(DEPTH)) ifb ();

    uart_tx_buffered #(.CLKS_PER_BIT(CPB_A), .FIFO_DEPTH(DEPTH), .STOP_BITS(STOP_A)) dut_a (
        .clk_50m(clk_50m), .rst_n(rst_n), .bus(ifa)
    );
    uart_tx_buffered #(.CLKS_PER_BIT(CPB_B), .FIFO_DEPTH(DEPTH), .STOP_BITS(STOP_B)) dut_b (
        .clk_50m(clk_50m), .rst_n(rst_n), .bus(ifb)
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    logic [7:0] sb_a[$];
    logic [7:0] sb_b[$];
    int rx_cnt[2] = '{0, 0};
    int ovf_b = 0;

    bit         mon_act[2]  = '{0, 0};
    int         mon_cnt[2]  = '{0, 0};
    logic       mon_prev[2] = '{1'b1, 1'b1};
    logic [7:0] mon_sh[2]   = '{8'h00, 8'h00};
    int         mon_last[2] = '{-1, -1};
    bit         b2b_en[2]   = '{0, 0};

    always @(posedge clk_50m) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk_50m);
        #1;
    endtask

    // Receiver model: samples mid-bit, checks start/stop levels, compares against the scoreboard
    task automatic mon(input int id, input logic txv, input int cpb, input int nstop);
        int k;
        logic [7:0] exp;
        if (!rst_n) begin
            mon_act[id]  = 0;
            mon_prev[id] = 1'b1;
        end else begin
            if (!mon_act[id]) begin
                if (mon_prev[id] && !txv) begin
                    mon_act[id] = 1;
                    mon_cnt[id] = 0;
                    if (b2b_en[id] && mon_last[id] >= 0)
                        chk($sformatf("b2b_spacing_%0d", id), cyc - mon_last[id], (9 + nstop) * cpb + 1);
                    mon_last[id] = cyc;
                end
            end else begin
                mon_cnt[id]++;
            end
            if (mon_act[id] && (mon_cnt[id] % cpb) == cpb / 2) begin
                k = mon_cnt[id] / cpb;
                if (k == 0) begin
                    chk($sformatf("rx_start_%0d", id), txv, 0);
                end else if (k <= 8) begin
                    mon_sh[id] = {txv, mon_sh[id][7:1]};
                end else begin
                    chk($sformatf("rx_stop_%0d", id), txv, 1);
                    if (k == 8 + nstop) begin
                        mon_act[id] = 0;
                        if ((id == 0 ? sb_a.size() : sb_b.size()) == 0) begin
                            chk($sformatf("rx_unexpected_frame_%0d", id), mon_sh[id], 32'hFFFF_FFFF);
                        end else begin
                            exp = (id == 0) ? sb_a.pop_front() : sb_b.pop_front();
                            chk($sformatf("rx_byte_%0d", id), mon_sh[id], exp);
                            rx_cnt[id]++;
                        end
                    end
                end
            end
            mon_prev[id] = txv;
        end
    endtask

    always @(posedge clk_50m) begin
        #1;
        mon(0, ifa.tx, CPB_A, STOP_A);
        mon(1, ifb.tx, CPB_B, STOP_B);
        if (rst_n && ifb.overflow) ovf_b++;
    end

    task automatic wait_idle(input int id, input int bound, input string nm);
        int n = 0;
        while (((id == 0) ? ifa.tx_busy : ifb.tx_busy) !== 1'b0 && n < bound) begin
            tick();
            n++;
        end
        chk(nm, (id == 0) ? ifa.tx_busy : ifb.tx_busy, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic fr_a5[10];
        vec_t vt[11];
        run_t runs[3];
        logic [7:0] rnd[9];
        logic model_full;
        int bad, e1, t0, n, sent, full_seen;
        logic [7:0] b;

        ifa.wr_en = 1'b0; ifa.din = '0;
        ifb.wr_en = 1'b0; ifb.din = '0;

        // reset state
        repeat (3) tick();
        chk("rst_tx_a", ifa.tx, 1);
        chk("rst_busy_a", ifa.tx_busy, 0);
        chk("rst_full_a", ifa.full, 0);
        chk("rst_count_a", ifa.fifo_count, 0);
        chk("rst_ovf_a", ifa.overflow, 0);
        chk("rst_tx_b", ifb.tx, 1);
        chk("rst_busy_b", ifb.tx_busy, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // single 0xA5 frame, bit-exact line check
        fr_a5 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        ifa.din = 8'hA5; ifa.wr_en = 1'b1; sb_a.push_back(8'hA5);
        tick();
        ifa.wr_en = 1'b0;
        chk("t1_tx_edgeN", ifa.tx, 1);
        tick();
        chk("t1_tx_edgeN1", ifa.tx, 1);
        chk("t1_busy_edgeN1", ifa.tx_busy, 1);
        tick();
        for (int bi = 0; bi < 10; bi++) begin
            bad = 0;
            for (int j = 0; j < CPB_A; j++) begin
                if (ifa.tx !== fr_a5[bi]) bad++;
                if (bi == 9 && j == CPB_A - 1) chk("t1_busy_last_stop_cycle", ifa.tx_busy, 1);
                tick();
            end
            chk($sformatf("t1_bit%0d_errs", bi), bad, 0);
        end
        chk("t1_busy_after_4340", ifa.tx_busy, 0);
        chk("t1_tx_idle", ifa.tx, 1);
        chk("t1_rx_count", rx_cnt[0], 1);

        // burst fill to full, then a rejected write
        for (int i = 0; i < 9; i++) rnd[i] = 8'($urandom);
        vt[0]  = '{wr: 1'b1, din: rnd[0], cnt: 1, full: 1'b0, ovf: 1'b0};
        vt[1]  = '{wr: 1'b1, din: rnd[1], cnt: 1, full: 1'b0, ovf: 1'b0};
        vt[2]  = '{wr: 1'b1, din: rnd[2], cnt: 2, full: 1'b0, ovf: 1'b0};
        vt[3]  = '{wr: 1'b1, din: rnd[3], cnt: 3, full: 1'b0, ovf: 1'b0};
        vt[4]  = '{wr: 1'b1, din: rnd[4], cnt: 4, full: 1'b0, ovf: 1'b0};
        vt[5]  = '{wr: 1'b1, din: rnd[5], cnt: 5, full: 1'b0, ovf: 1'b0};
        vt[6]  = '{wr: 1'b1, din: rnd[6], cnt: 6, full: 1'b0, ovf: 1'b0};
        vt[7]  = '{wr: 1'b1, din: rnd[7], cnt: 7, full: 1'b0, ovf: 1'b0};
        vt[8]  = '{wr: 1'b1, din: rnd[8], cnt: 8, full: 1'b1, ovf: 1'b0};
        vt[9]  = '{wr: 1'b1, din: 8'h3C,  cnt: 8, full: 1'b1, ovf: 1'b1};
        vt[10] = '{wr: 1'b0, din: 8'h00,  cnt: 8, full: 1'b1, ovf: 1'b0};
        b2b_en[0] = 1; mon_last[0] = -1;
        model_full = 1'b0;
        e1 = 0;
        for (int i = 0; i < 11; i++) begin
            ifa.wr_en = vt[i].wr; ifa.din = vt[i].din;
            if (vt[i].wr && !model_full) sb_a.push_back(vt[i].din);
            tick();
            if (i == 0) e1 = cyc;
            chk($sformatf("t2_count_row%0d", i), ifa.fifo_count, vt[i].cnt);
            chk($sformatf("t2_full_row%0d", i), ifa.full, vt[i].full);
            chk($sformatf("t2_ovf_row%0d", i), ifa.overflow, vt[i].ovf);
            model_full = vt[i].full;
        end
        ifa.wr_en = 1'b0;

        // write while full on the very edge of the second pop
        while (cyc < e1 + 4341) tick();
        ifa.din = 8'h3C; ifa.wr_en = 1'b1;
        tick();
        ifa.wr_en = 1'b0;
        chk("t3_pop_edge_count", ifa.fifo_count, 7);
        chk("t3_pop_edge_ovf", ifa.overflow, 1);
        chk("t3_pop_edge_full", ifa.full, 0);
        tick();
        chk("t3_ovf_one_cycle", ifa.overflow, 0);
        chk("t3_count_hold", ifa.fifo_count, 7);
        wait_idle(0, 9 * 4341 + 100, "t2_drain_timeout");
        chk("t2_count_empty", ifa.fifo_count, 0);
        chk("t2_sb_empty", sb_a.size(), 0);
        chk("t2_rx_count", rx_cnt[0], 10);
        b2b_en[0] = 0;

        // reset mid-frame with 3 bytes queued
        for (int i = 0; i < 4; i++) begin
            ifa.din = 8'(8'h10 + i); ifa.wr_en = 1'b1; sb_a.push_back(ifa.din);
            tick();
        end
        ifa.wr_en = 1'b0;
        chk("t4_queued", ifa.fifo_count, 3);
        repeat (1000) tick();
        #4 rst_n = 1'b0;
        #1;
        chk("t4_rst_tx", ifa.tx, 1);
        chk("t4_rst_count", ifa.fifo_count, 0);
        chk("t4_rst_busy", ifa.tx_busy, 0);
        sb_a.delete();
        tick(); tick();
        rst_n = 1'b1;
        bad = 0;
        for (int j = 0; j < 10000; j++) begin
            tick();
            if (ifa.tx !== 1'b1 || ifa.tx_busy !== 1'b0) bad++;
        end
        chk("t4_quiet_after_reset", bad, 0);
        chk("t4_rx_count", rx_cnt[0], 10);

        // 8N2 at 4 clocks/bit: 0x00 then 0xFF
        ifb.din = 8'h00; ifb.wr_en = 1'b1; sb_b.push_back(8'h00);
        tick();
        ifb.din = 8'hFF; sb_b.push_back(8'hFF);
        tick();
        ifb.wr_en = 1'b0;
        tick();
        chk("t5_tx_fall", ifb.tx, 0);
        t0 = cyc;
        runs[0] = '{lvl: 1'b0, len: 36};
        runs[1] = '{lvl: 1'b1, len: 9};
        runs[2] = '{lvl: 1'b0, len: 4};
        for (int r = 0; r < 3; r++) begin
            n = 0;
            while (ifb.tx === runs[r].lvl && n < 200) begin
                n++;
                tick();
            end
            chk($sformatf("t5_run%0d_len", r), n, runs[r].len);
        end
        wait_idle(1, 200, "t5_idle_timeout");
        chk("t5_total_clocks", cyc - t0, 89);
        chk("t5_rx_count", rx_cnt[1], 2);

        // random stream gated by full
        sent = 0; full_seen = 0; n = 0;
        while (sent < 200 && n < 60000) begin
            repeat ($urandom_range(0, 50)) begin tick(); n++; end
            while (ifb.full && n < 60000) begin full_seen++; tick(); n++; end
            b = 8'($urandom);
            ifb.din = b; ifb.wr_en = 1'b1; sb_b.push_back(b);
            tick(); n++;
            ifb.wr_en = 1'b0;
            sent++;
        end
        chk("t6_sent", sent, 200);
        wait_idle(1, DEPTH * 45 + 200, "t6_drain_timeout");
        chk("t6_rx_count", rx_cnt[1], 202);
        chk("t6_sb_empty", sb_b.size(), 0);
        chk("t6_count_empty", ifb.fifo_count, 0);
        chk("t6_no_overflow", ovf_b, 0);
        chk("t6_full_reached", full_seen > 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
